prog_ram: RTL and testbench

- Parametrised program/data memory for the 4-bit CPU, the next generation of the 8x16 program RAM.
- On every reset an init FSM copies the boot image from the shared package into memory.
- A streaming valid/ready loader port lets a host (UART bridge, test harness) overwrite the whole program without resynthesis.
- The CPU sees one read port (combinational or registered, per parameter) and one write port; the CPU is stalled via `busy` while init or load is in progress.

---
 rtl/prog_pkg.sv | 29 ++
 rtl/prog_ram_loader.sv | 122 ++++++++++++
 rtl/prog_ram.sv | 80 ++++++++
 tb/tb_prog_ram.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the program RAM: the boot image copied in on every
// reset and the controller state encoding.
package prog_pkg;

    localparam int unsigned BOOT_LEN = 6;

    // mvi R0,1 / lrotate R0 / inc R6 / mov R1,R0 / inc R1 / jmp 1
    localparam logic [7:0] BOOT_IMAGE [16] = '{
        8'hA1, 8'h78, 8'h66, 8'h08, 8'h61, 8'h91, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        LOAD = 2'd2
    } ram_state_e;

    function automatic logic [7:0] boot_byte(input int unsigned idx);
        logic [7:0] val;
        if (idx < BOOT_LEN) begin
            val = BOOT_IMAGE[idx[3:0]];
        end else begin
            val = 8'h00;
        end
        return val;
    endfunction

endpackage

// File: rtl/prog_ram_loader.sv
// Controller for the program RAM: boot-image copy, host streaming load and
// arbitration of the single memory write port between init, loader and CPU.
module prog_ram_loader
    import prog_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              busy_o,
    output logic              wr_drop_o,
    output logic              ld_ready_o,
    output logic              ld_done_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o
);

    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};

    ram_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              ld_ready_q;
    logic              ld_done_q;
    logic              wr_drop_q;

    logic [DATA_W-1:0] boot_s;
    logic              write_s;
    logic              accept_s;

    // Init and loader own the write port outside IDLE, so the CPU can never corrupt them.
    always_comb begin
        boot_s     = DATA_W'(boot_byte(32'(ptr_q)));
        write_s    = 1'b0;
        accept_s   = 1'b0;
        mem_addr_o = ptr_q;
        mem_data_o = boot_s;
        case (state_q)
            INIT: begin
                write_s = 1'b1;
            end
            LOAD: begin
                accept_s   = ld_valid_i & ld_ready_q;
                write_s    = accept_s;
                mem_data_o = ld_data_i;
            end
            IDLE: begin
                write_s    = we_i;
                mem_addr_o = w_addr_i;
                mem_data_o = w_data_i;
            end
            default: begin
                write_s = 1'b0;
            end
        endcase
        mem_we_o = write_s & ~rst;
    end

    // Controller state, pointer and all registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            ptr_q      <= PTR_ZERO;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            wr_drop_q <= we_i & (state_q != IDLE);
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (ld_start_i) begin
                        state_q    <= LOAD;
                        ptr_q      <= PTR_ZERO;
                        busy_q     <= 1'b1;
                        ld_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (ptr_q == PTR_LAST) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= INIT;
                    ptr_q      <= PTR_ZERO;
                    busy_q     <= 1'b1;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign wr_drop_o  = wr_drop_q;
    assign ld_ready_o = ld_ready_q;
    assign ld_done_o  = ld_done_q;

endmodule

// File: rtl/prog_ram.sv
// Parametrised program/data RAM for the 4-bit CPU: memory array, read path
// (combinational or registered write-first) and the init/loader controller.
module prog_ram
    import prog_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned REG_READ = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              wr_drop,
    input  logic              ld_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;

    prog_ram_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we),
        .w_addr_i   (w_addr),
        .w_data_i   (w_data),
        .ld_start_i (ld_start),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .busy_o     (busy),
        .wr_drop_o  (wr_drop),
        .ld_ready_o (ld_ready),
        .ld_done_o  (ld_done),
        .mem_we_o   (mem_we_s),
        .mem_addr_o (mem_addr_s),
        .mem_data_o (mem_data_s)
    );

    // Contents survive reset on purpose; INIT rewrites every word anyway.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= mem_data_s;
        end
    end

    if (REG_READ != 32'd0) begin : g_reg_read
        logic [DATA_W-1:0] r_data_q;

        // Registered read with bypass so a same-cycle write to r_addr is returned.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data_q <= {DATA_W{1'b0}};
            end else if (mem_we_s && (mem_addr_s == r_addr)) begin
                r_data_q <= mem_data_s;
            end else begin
                r_data_q <= mem_q[r_addr];
            end
        end

        assign r_data = r_data_q;
    end else begin : g_comb_read
        assign r_data = mem_q[r_addr];
    end

endmodule

// File: tb/tb_prog_ram.sv
// Randomised self-checking bench for prog_ram; both read variants run side by
// side on the same stimulus and are compared against a plain array model.
module tb_prog_ram;

    localparam logic [7:0] BOOT [6] = '{8'hA1, 8'h78, 8'h66, 8'h08, 8'h61, 8'h91};

    logic       clk = 1'b0;
    logic       rst, we, ld_start, ld_valid;
    logic [3:0] r_addr, w_addr;
    logic [7:0] w_data, ld_data;
    logic [7:0] r_data0, r_data1;
    logic       busy0, busy1, wr_drop0, wr_drop1;
    logic       ld_ready0, ld_ready1, ld_done0, ld_done1;
    logic [3:0] ctl0, ctl1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mdl [16];

    always #5 clk = ~clk;

    assign ctl0 = {busy0, ld_ready0, ld_done0, wr_drop0};
    assign ctl1 = {busy1, ld_ready1, ld_done1, wr_drop1};

    prog_ram #(.DATA_W(8), .ADDR_W(4), .REG_READ(0)) dut0 (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data0), .we(we),
        .w_addr(w_addr), .w_data(w_data), .busy(busy0), .wr_drop(wr_drop0),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready0),
        .ld_data(ld_data), .ld_done(ld_done0)
    );

    prog_ram #(.DATA_W(8), .ADDR_W(4), .REG_READ(1)) dut1 (
        .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data1), .we(we),
        .w_addr(w_addr), .w_data(w_data), .busy(busy1), .wr_drop(wr_drop1),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready1),
        .ld_data(ld_data), .ld_done(ld_done1)
    );

    function automatic logic [7:0] boot_val(input int i);
        return (i < 6) ? BOOT[i] : 8'h00;
    endfunction

    task automatic load_boot_model();
        for (int i = 0; i < 16; i++) mdl[i] = boot_val(i);
    endtask

    // Reads every address through both ports; caller guarantees no writes in flight.
    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) begin
            r_addr = 4'(a);
            #1;
            checks++;
            if (r_data0 !== mdl[a]) begin
                errors++;
                $display("FAIL %s comb addr %0d: got %h expected %h", tag, a, r_data0, mdl[a]);
            end
            @(negedge clk);
            checks++;
            if (r_data1 !== mdl[a]) begin
                errors++;
                $display("FAIL %s reg addr %0d: got %h expected %h", tag, a, r_data1, mdl[a]);
            end
        end
    endtask

    // Reset values, INIT duration, dropped CPU writes and ignored ld_start during INIT.
    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1; we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
        r_addr = 4'd0; w_addr = 4'd0; w_data = 8'h00; ld_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (ctl0 !== 4'b1000 || ctl1 !== 4'b1000 || r_data1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: ctl %b/%b rdata %h expected 1000 and 00", ctl0, ctl1, r_data1);
        end
        rst = 1'b0;
        ld_start = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            we = 1'($urandom_range(0, 1));
            w_addr = 4'($urandom);
            w_data = 8'($urandom);
            exp = {(k < 16), 2'b00, we};
            @(negedge clk);
            checks++;
            if (ctl0 !== exp || ctl1 !== exp) begin
                errors++;
                $display("FAIL init_cycle %0d: ctl %b/%b expected %b", k, ctl0, ctl1, exp);
            end
        end
        ld_start = 1'b0;
        we = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl0 !== 4'b0000 || ctl1 !== 4'b0000) begin
            errors++;
            $display("FAIL init_ignores_start: ctl %b/%b expected 0000", ctl0, ctl1);
        end
        load_boot_model();
    endtask

    // Random CPU writes in IDLE, including same-address read for write-first.
    task automatic test_cpu_write();
        logic [7:0] exp_r;
        for (int n = 0; n < 24; n++) begin
            if (n == 0) begin
                we = 1'b1; w_addr = 4'd3; w_data = 8'h5A; r_addr = 4'd3;
            end else begin
                we = 1'($urandom_range(0, 1));
                w_addr = 4'($urandom);
                w_data = 8'($urandom);
                r_addr = ($urandom_range(0, 1) == 0) ? w_addr : 4'($urandom);
            end
            #1;
            checks++;
            if (r_data0 !== mdl[r_addr]) begin
                errors++;
                $display("FAIL cpu_pre_read %0d: got %h expected %h", n, r_data0, mdl[r_addr]);
            end
            exp_r = (we && w_addr == r_addr) ? w_data : mdl[r_addr];
            if (we) mdl[w_addr] = w_data;
            @(negedge clk);
            checks++;
            if (r_data1 !== exp_r || r_data0 !== mdl[r_addr] || ctl0 !== 4'b0000 || ctl1 !== 4'b0000) begin
                errors++;
                $display("FAIL cpu_write %0d: r %h/%h expected %h/%h ctl %b/%b expected 0000",
                         n, r_data0, r_data1, mdl[r_addr], exp_r, ctl0, ctl1);
            end
        end
        we = 1'b0;
    endtask

    // Full-memory stream load with stalls and CPU writes that must be dropped.
    task automatic test_load(input bit directed);
        logic [7:0] words [16];
        logic [7:0] exp_r;
        logic [3:0] exp;
        logic       acc_last;
        bit         drop_sent;
        int         idx, gap, pulses, budget;
        for (int i = 0; i < 16; i++) words[i] = directed ? 8'(8'h10 + i) : 8'($urandom);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        checks++;
        if (ctl0 !== 4'b1100 || ctl1 !== 4'b1100) begin
            errors++;
            $display("FAIL load_enter: ctl %b/%b expected 1100", ctl0, ctl1);
        end
        idx = 0; gap = 0; pulses = 0; budget = 0; drop_sent = 0;
        while (idx < 16 && budget < 200) begin
            budget++;
            ld_valid = directed ? (gap == 0) : ($urandom_range(0, 3) != 0);
            ld_data = ld_valid ? words[idx] : 8'($urandom);
            if (directed) begin
                we = (idx == 4 && !drop_sent);
                w_addr = 4'd0;
                w_data = 8'hFF;
            end else begin
                we = ($urandom_range(0, 3) == 0);
                w_addr = 4'($urandom);
                w_data = 8'($urandom);
            end
            if (we) drop_sent = 1;
            r_addr = ($urandom_range(0, 1) == 0) ? 4'(idx) : 4'($urandom);
            #1;
            checks++;
            if (r_data0 !== mdl[r_addr]) begin
                errors++;
                $display("FAIL load_pre_read: got %h expected %h", r_data0, mdl[r_addr]);
            end
            exp_r = (ld_valid && idx == int'(r_addr)) ? ld_data : mdl[r_addr];
            acc_last = ld_valid && (idx == 15);
            if (ld_valid) begin
                mdl[idx] = ld_data;
                idx++;
                if (directed && idx == 8) gap = 3;
            end else if (gap > 0) begin
                gap--;
            end
            @(negedge clk);
            exp = {(idx != 16), (idx != 16), acc_last, we};
            if (ld_done0) pulses++;
            checks++;
            if (ctl0 !== exp || ctl1 !== exp || r_data1 !== exp_r) begin
                errors++;
                $display("FAIL load_word %0d: ctl %b/%b expected %b r %h expected %h",
                         idx, ctl0, ctl1, exp, r_data1, exp_r);
            end
        end
        checks++;
        if (idx != 16) begin
            errors++;
            $display("FAIL load_timeout: accepted %0d words, required 16", idx);
        end
        ld_valid = 1'b0;
        we = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl0 !== 4'b0000 || ctl1 !== 4'b0000 || pulses != 1 || drop_sent == 0) begin
            errors++;
            $display("FAIL load_finish: ctl %b/%b done pulses %0d expected 0000 and 1", ctl0, ctl1, pulses);
        end
    endtask

    // Reset after five loaded words: abandon load, no ld_done, INIT reruns.
    task automatic test_reset_mid_load();
        int pulses;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data = 8'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        ld_data = 8'($urandom);
        @(negedge clk);
        rst = 1'b0;
        ld_valid = 1'b0;
        checks++;
        if (ctl0 !== 4'b1000 || ctl1 !== 4'b1000) begin
            errors++;
            $display("FAIL midload_reset: ctl %b/%b expected 1000", ctl0, ctl1);
        end
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_data = 8'($urandom);
            @(negedge clk);
            if (ld_done0 || ld_done1) pulses++;
            checks++;
            if (busy0 !== (k < 16) || busy1 !== (k < 16) || ld_ready0 !== 1'b0 || ld_ready1 !== 1'b0) begin
                errors++;
                $display("FAIL reinit_cycle %0d: busy %b/%b ready %b/%b expected busy %0d ready 0",
                         k, busy0, busy1, ld_ready0, ld_ready1, (k < 16));
            end
        end
        ld_valid = 1'b0;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midload_no_done: got %0d ld_done pulses expected 0", pulses);
        end
        load_boot_model();
    endtask

    initial begin
        test_reset();
        read_all("boot_image");
        test_cpu_write();
        test_load(1'b1);
        read_all("load_directed");
        test_load(1'b0);
        read_all("load_random");
        test_reset_mid_load();
        read_all("boot_after_reset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
